// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encodings, default size
// and the operand-width helper.
package nibble_add_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int NIB_DEFAULT = 4;

  function automatic int op_width(input int nib);
    return 4 * nib;
  endfunction

endpackage

// File: rtl/nibble_add_seq_if.sv
// Request/result bundle between the lab top level (master) and the
// nibble-serial adder (slave).
interface nibble_add_seq_if
  import nibble_add_seq_pkg::*;
#(
  parameter int NIB = NIB_DEFAULT
);
  localparam int W = op_width(NIB);

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/nibble_add_seq_rca4.sv
// 4-bit ripple-carry slice built from full-adder cells; purely combinational.
module nibble_add_seq_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  // Full-adder chain, bit 0 first.
  always_comb begin
    c    = 5'b0_0000;
    s    = 4'h0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial W-bit add/subtract: one 4-bit slice reused for NIB cycles,
// least-significant nibble first, with a start/done handshake.
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int NIB = NIB_DEFAULT
) (
  input logic             CLOCK_50,
  input logic             reset,
  nibble_add_seq_if.slave bus
);

  localparam int W  = op_width(NIB);
  localparam int KW = $clog2(NIB);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] opa_q, opa_d;
  logic [W-1:0] opb_q, opb_d;
  logic [W-5:0] acc_q, acc_d;
  logic [W-1:0] acc_all;
  logic [W-1:0] sum_q, sum_d;
  logic [KW-1:0] k_q, k_d;
  logic         carry_q, carry_d;
  logic         amsb_q, amsb_d;
  logic         bmsb_q, bmsb_d;
  logic         cout_q, cout_d;
  logic         ovf_q, ovf_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [3:0]   s4;
  logic         c4;

  nibble_add_seq_rca4 u_rca4 (
    .a    (opa_q[3:0]),
    .b    (opb_q[3:0]),
    .cin  (carry_q),
    .s    (s4),
    .cout (c4)
  );

  // New nibble enters at the top; after NIB steps acc_all is the full result.
  assign acc_all = {s4, acc_q};

  // Next-state logic for FSM, operand shifters, carry chain and results.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    k_d     = k_q;
    carry_d = carry_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          amsb_d  = bus.a[W-1];
          bmsb_d  = bus.sub ? ~bus.b[W-1] : bus.b[W-1];
          k_d     = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        opa_d   = {4'h0, opa_q[W-1:4]};
        opb_d   = {4'h0, opb_q[W-1:4]};
        acc_d   = acc_all[W-1:4];
        carry_d = c4;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NIB - 1)) begin
          // Outputs move only here, so partial sums are never visible.
          sum_d   = acc_all;
          cout_d  = c4;
          ovf_d   = (amsb_q == bmsb_q) && (s4[3] != amsb_q);
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State registers with synchronous reset that also drops any in-flight op.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed-vector bench for nibble_add_seq with NIB=4 (16-bit operands).
module tb_nibble_add_seq;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   n_vec    = 0;
  int   n_err    = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  nibble_add_seq_if #(.NIB(4)) bus ();

  nibble_add_seq #(.NIB(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Drive operands with start high across one edge (e0), then drop start.
  task automatic launch(input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin);
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    bus.cin   = cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Called just after e0; returns the edge index of done (-1 on timeout),
  // the number of busy samples before done, and whether sum stayed frozen.
  task automatic wait_done(output int cyc, output int busy_n, output bit held);
    logic [15:0] s0;
    s0     = bus.sum;
    held   = 1'b1;
    cyc    = -1;
    busy_n = (bus.busy === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.sum !== s0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    tick();
    tick();
    n_vec++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum} !== 20'h0_0000) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
               bus.busy, bus.done, bus.cout, bus.ovf, bus.sum);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add_basic();
    int cyc, bn;
    bit held;
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(cyc, bn, held);
    n_vec++;
    if (cyc !== 4) begin
      n_err++;
      $display("FAIL add_basic_latency: done at edge %0d, want 4", cyc);
    end
    n_vec++;
    if (bn !== 4) begin
      n_err++;
      $display("FAIL add_basic_busy: busy for %0d cycles, want 4", bn);
    end
    n_vec++;
    if (!held) begin
      n_err++;
      $display("FAIL add_basic_partial: sum changed while busy (got 1, want 0)");
    end
    n_vec++;
    if ({bus.sum, bus.cout, bus.ovf, bus.busy} !== {16'h5555, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL add_basic_result: got sum=%h cout=%b ovf=%b busy=%b, want 5555 0 0 0",
               bus.sum, bus.cout, bus.ovf, bus.busy);
    end
    tick();
    n_vec++;
    if ({bus.done, bus.sum} !== {1'b0, 16'h5555}) begin
      n_err++;
      $display("FAIL add_basic_pulse: got done=%b sum=%h, want 0 5555", bus.done, bus.sum);
    end
  endtask

  task automatic test_add_carry();
    int cyc, bn;
    bit held;
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc, bn, held);
    n_vec++;
    if ({cyc == 4, bus.sum, bus.cout, bus.ovf} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL add_wrap: got edge=%0d sum=%h cout=%b ovf=%b, want 4 0000 1 0",
               cyc, bus.sum, bus.cout, bus.ovf);
    end
    tick();
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc, bn, held);
    n_vec++;
    if ({cyc == 4, bus.sum, bus.cout, bus.ovf} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL add_ovf: got edge=%0d sum=%h cout=%b ovf=%b, want 4 8000 0 1",
               cyc, bus.sum, bus.cout, bus.ovf);
    end
    tick();
    launch(16'h00FF, 16'h0001, 1'b0, 1'b1);
    wait_done(cyc, bn, held);
    n_vec++;
    if ({cyc == 4, bus.sum, bus.cout, bus.ovf} !== {1'b1, 16'h0101, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL add_cin: got edge=%0d sum=%h cout=%b ovf=%b, want 4 0101 0 0",
               cyc, bus.sum, bus.cout, bus.ovf);
    end
    tick();
  endtask

  task automatic test_sub();
    int cyc, bn;
    bit held;
    launch(16'h0005, 16'h0007, 1'b1, 1'b0);
    wait_done(cyc, bn, held);
    n_vec++;
    if ({cyc == 4, bus.sum, bus.cout, bus.ovf} !== {1'b1, 16'hFFFE, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_borrow: got edge=%0d sum=%h cout=%b ovf=%b, want 4 fffe 0 0",
               cyc, bus.sum, bus.cout, bus.ovf);
    end
    tick();
    launch(16'h8000, 16'h0001, 1'b1, 1'b0);
    wait_done(cyc, bn, held);
    n_vec++;
    if ({cyc == 4, bus.sum, bus.cout, bus.ovf} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL sub_ovf: got edge=%0d sum=%h cout=%b ovf=%b, want 4 7fff 1 1",
               cyc, bus.sum, bus.cout, bus.ovf);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int pulses, first;
    logic [15:0] s_at;
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    bus.a     = 16'hAAAA;
    bus.b     = 16'h5555;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = (bus.done === 1'b1) ? 1 : 0;
    first  = (bus.done === 1'b1) ? 1 : -1;
    s_at   = 16'h0000;
    for (int i = 2; i <= 12; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = i;
          s_at  = bus.sum;
        end
      end
    end
    n_vec++;
    if ({pulses == 1, first == 4, s_at} !== {1'b1, 1'b1, 16'h3333}) begin
      n_err++;
      $display("FAIL start_ignored: got pulses=%0d edge=%0d sum=%h, want 1 4 3333",
               pulses, first, s_at);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bn, extra;
    bit held;
    launch(16'h1357, 16'h0101, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum} !== 20'h0_0000) begin
      n_err++;
      $display("FAIL reset_mid_run: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
               bus.busy, bus.done, bus.cout, bus.ovf, bus.sum);
    end
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d busy/done cycles, want 0", extra);
    end
    launch(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    wait_done(cyc, bn, held);
    n_vec++;
    if ({cyc == 4, bus.sum, bus.cout, bus.ovf} !== {1'b1, 16'h1010, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_recover: got edge=%0d sum=%h cout=%b ovf=%b, want 4 1010 0 0",
               cyc, bus.sum, bus.cout, bus.ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses, bad_sum, bad_pos;
    bus.a     = 16'h2468;
    bus.b     = 16'h1357;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    pulses  = 0;
    bad_sum = 0;
    bad_pos = 0;
    // Edge t=0 is the first accepted start; done expected at t=4,9,14,19.
    for (int t = 0; t <= 20; t++) begin
      tick();
      if (bus.done === 1'b1) begin
        pulses++;
        if (bus.sum !== 16'h37BF) bad_sum++;
        if ((t % 5) != 4) bad_pos++;
      end
    end
    bus.start = 1'b0;
    n_vec++;
    if ({pulses, bad_sum, bad_pos} !== {32'd4, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL back_to_back: got pulses=%0d bad_sum=%0d bad_pos=%0d, want 4 0 0",
               pulses, bad_sum, bad_pos);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
